// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: ID/EXE/MEM hazard
// inputs, SRAM handshake, and the stall/flush/statistics outputs.
interface hazard_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;
    logic             ID_valid;
    logic [3:0]       EXE_Dest;
    logic             EXE_WB_EN;
    logic             EXE_MEM_R_EN;
    logic [3:0]       MEM_Dest;
    logic             MEM_WB_EN;
    logic             Forwarding_EN;
    logic             MEM_access;
    logic             mem_ready;
    logic             Branch_taken;
    logic             freeze_IF_ID;
    logic             bubble_ID_EXE;
    logic             freeze_all;
    logic             flush;
    logic             mem_error;
    logic             state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] wait_cycles;

    modport master (
        output src1, src2, two_src, ID_valid, EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, Forwarding_EN, MEM_access, mem_ready, Branch_taken,
        input  freeze_IF_ID, bubble_ID_EXE, freeze_all, flush, mem_error, state,
               stall_cycles, wait_cycles
    );

    modport slave (
        input  src1, src2, two_src, ID_valid, EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, Forwarding_EN, MEM_access, mem_ready, Branch_taken,
        output freeze_IF_ID, bubble_ID_EXE, freeze_all, flush, mem_error, state,
               stall_cycles, wait_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall scheduler for the 5-stage core: load-use and RAW bubbles,
// SRAM-wait freeze with timeout watchdog, branch flush, saturating statistics.
module hazard_stall_controller #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic                      clk,
    input logic                      rst,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_wait_len;
    logic [15:0]      w_wait_len_next;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_wait_cycles;

    logic w_m_exe;
    logic w_m_mem;
    logic w_hazard_raw;
    logic w_freeze_all;
    logic w_hazard;
    logic w_flush;
    logic w_timeout_hit;

    always_comb begin
        w_m_exe = (bus.src1 == bus.EXE_Dest) | (bus.two_src & (bus.src2 == bus.EXE_Dest));
        w_m_mem = (bus.src1 == bus.MEM_Dest) | (bus.two_src & (bus.src2 == bus.MEM_Dest));
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (bus.Forwarding_EN)
            w_hazard_raw = bus.ID_valid & w_m_exe & bus.EXE_MEM_R_EN;
        else
            w_hazard_raw = bus.ID_valid & ((w_m_exe & bus.EXE_WB_EN) | (w_m_mem & bus.MEM_WB_EN));
        w_freeze_all  = bus.MEM_access & ~bus.mem_ready & ~r_mem_error;
        w_flush       = bus.Branch_taken & ~w_freeze_all;
        w_hazard      = w_hazard_raw & ~w_freeze_all & ~bus.Branch_taken;
        w_timeout_hit = w_freeze_all & (r_wait_len == 16'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_len <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_len <= w_wait_len_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_len_next = r_wait_len;
        case (r_state)
            RUN: begin
                if (w_freeze_all) begin
                    w_state_next    = MEM_WAIT;
                    w_wait_len_next = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!w_freeze_all) begin
                    w_state_next    = RUN;
                    w_wait_len_next = '0;
                end else begin
                    w_wait_len_next = r_wait_len + 16'd1;
                end
            end
            default: begin
                w_state_next    = RUN;
                w_wait_len_next = '0;
            end
        endcase
    end

    always_comb begin
        bus.freeze_IF_ID  = w_hazard | w_freeze_all;
        bus.bubble_ID_EXE = w_hazard;
        bus.freeze_all    = w_freeze_all;
        bus.flush         = w_flush;
        bus.mem_error     = r_mem_error;
        bus.state         = (r_state == MEM_WAIT);
        bus.stall_cycles  = r_stall_cycles;
        bus.wait_cycles   = r_wait_cycles;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_error    <= 1'b0;
            r_stall_cycles <= '0;
            r_wait_cycles  <= '0;
        end else begin
            if (w_timeout_hit)
                r_mem_error <= 1'b1;
            if (w_hazard && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_freeze_all && (r_wait_cycles != '1))
                r_wait_cycles <= r_wait_cycles + 1'b1;
        end
    end
endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline hazard and stall scheduler for the 5-stage ARM core. Sits beside the forwarding unit in ID/EXE and decides, each cycle, whether the front end holds, whether a bubble enters ID/EXE, whether the whole pipeline freezes for an outstanding SRAM access, and whether the front end is flushed on a taken branch. It also tracks the SRAM wait with a timeout watchdog and keeps saturating stall statistics.

## Interface
- TIMEOUT, 64: consecutive SRAM-wait cycles after which `mem_error` is raised (2..65535).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- src1, src2  in  4  ID-stage source registers.
- two_src  in  1  ID instruction reads src2.
- ID_valid  in  1  ID holds a real instruction.
- EXE_Dest  in  4  EXE destination register.
- EXE_WB_EN, EXE_MEM_R_EN  in  1  EXE writes back; EXE is a load.
- MEM_Dest  in  4  MEM destination register.
- MEM_WB_EN  in  1  MEM writes back.
- Forwarding_EN  in  1  forwarding unit active.
- MEM_access  in  1  MEM stage has a load/store in flight.
- mem_ready  in  1  SRAM controller completes the access this cycle.
- Branch_taken  in  1  EXE resolves a taken branch.
- freeze_IF_ID  out  1  hold PC and IF/ID.
- bubble_ID_EXE  out  1  load NOP into ID/EXE.
- freeze_all  out  1  hold every pipeline register and PC.
- flush  out  1  clear IF/ID and ID/EXE.
- mem_error  out  1  sticky SRAM timeout.
- state  out  1  0 = RUN, 1 = MEM_WAIT.
- stall_cycles  out  CNT_W  saturating count of hazard-bubble cycles.
- wait_cycles  out  CNT_W  saturating count of `freeze_all` cycles.

## Operation
- Match terms: m1 = (src1 == X), m2 = two_src & (src2 == X).
- hazard_raw, with Forwarding_EN = 0: ID_valid & [(m1|m2 on EXE_Dest) & EXE_WB_EN | (m1|m2 on MEM_Dest) & MEM_WB_EN].
- hazard_raw, with Forwarding_EN = 1: ID_valid & (m1|m2 on EXE_Dest) & EXE_MEM_R_EN. This is the load-use case only.
- freeze_all = MEM_access & ~mem_ready & ~mem_error. It is combinational and independent of state.
- flush = Branch_taken & ~freeze_all.
- hazard = hazard_raw & ~freeze_all & ~Branch_taken. A taken branch discards ID, so no stall is needed.
- freeze_IF_ID = hazard | freeze_all.
- bubble_ID_EXE = hazard.
- Priority: freeze_all > flush > hazard.
- FSM, RUN to MEM_WAIT: when freeze_all = 1. wait_len loads 1.
- FSM, MEM_WAIT to RUN: when freeze_all = 0 (mem_ready, MEM_access dropped, or error). wait_len clears.
- FSM, MEM_WAIT holds otherwise, with wait_len += 1.
- Watchdog: on the edge where the registered wait_len == TIMEOUT-1 while freeze_all = 1, mem_error is set. freeze_all drops from the next cycle, which is the TIMEOUT-th wait cycle plus one, and state returns to RUN.
- mem_error stays set until rst. While it is set, freeze_all is 0 and the pipeline runs on.
- Counters: stall_cycles += 1 on every edge with hazard = 1. wait_cycles += 1 on every edge with freeze_all = 1. Both saturate at 2^CNT_W − 1; no wrap.

## Timing
- Reset values, on the first edge with rst = 1: state = RUN, wait_len = 0, mem_error = 0, stall_cycles = 0, wait_cycles = 0.
- During rst the combinational outputs still follow their equations.
- rst mid-wait: the next cycle is RUN with counters zeroed. freeze_all reasserts immediately if MEM_access & ~mem_ready is still true.
- Latency: freeze_IF_ID, bubble_ID_EXE, freeze_all and flush are zero-cycle (combinational). mem_error, state and the counters are updated one edge after their cause.
- A load-use stall lasts exactly 1 cycle, because the next edge moves the load to MEM and hazard_raw falls.
- Without forwarding, a dependency on EXE stalls 2 cycles and one on MEM stalls 1.
- mem_ready in the first access cycle: freeze_all = 0 and no state change.
- Simultaneous Branch_taken and hazard_raw: flush = 1, bubble = 0, freeze_IF_ID = 0.
- Simultaneous freeze_all and Branch_taken: only freeze_all is asserted. The branch is re-presented after the freeze.
- src = 4'd15 (PC) is not special-cased.

## Test plan
- **Load-use.** Forwarding_EN = 1, EXE_MEM_R_EN = 1, EXE_Dest = 3, src1 = 3, ID_valid = 1 for one cycle. Expect freeze_IF_ID = bubble_ID_EXE = 1 for that cycle and stall_cycles = 1 after the edge. With two_src = 0 and src2 = 3 only, expect no stall.
- **No forwarding.** Forwarding_EN = 0, MEM_Dest = 5, MEM_WB_EN = 1, src2 = 5, two_src = 1. Expect a bubble. Setting MEM_WB_EN = 0 expects no bubble.
- **SRAM wait.** MEM_access = 1 with mem_ready low for 4 cycles, then high. Expect freeze_all = 1 for 4 cycles, state = MEM_WAIT on cycles 2–5, RUN after, and wait_cycles = 4.
- **Timeout.** TIMEOUT = 8, mem_ready stuck low. Expect freeze_all = 1 for exactly 8 cycles, mem_error = 1 from the 9th cycle, and freeze_all = 0 thereafter. Asserting rst clears mem_error and wait_cycles.
- **Priority.** Branch_taken together with a load-use hazard expects flush = 1 and bubble = 0. Adding MEM_access & ~mem_ready expects freeze_all = 1 and flush = 0.
- **Saturation.** CNT_W = 4, hazard held for 20 cycles. Expect stall_cycles to stick at 15.
